uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_rx_fifo.sv | 130 +++++++++++++
 tb/tb_uart_rx_fifo.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO between the UART Rx stage and its consumer, with a sticky overrun flag.
// Optional threshold interrupt (thresh/irq) is compiled in with `define UART_RX_FIFO_THRESH_IRQ_EN.
module uart_rx_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              glb_clk,
  input  logic              glb_rst,
  input  logic [7:0]        UART_Rx_data_payload,
  input  logic              UART_ctrl_FIFO_w_en,
  output logic              FIFO_ctrl_full,
  input  logic              rd_en,
  output logic [7:0]        rd_data,
  output logic              rd_valid,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  input  logic              flush,
  output logic              overrun,
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  input  logic [ADDR_W:0]   thresh,
  output logic              irq,
`endif
  input  logic              ovr_clr
);

  localparam logic [ADDR_W:0]   FULL_LVL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   ZERO_LVL = (ADDR_W+1)'(0);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W+1)'(1);

  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic [7:0]        rd_data_r;
  logic              rd_valid_r;
  logic              overrun_r;

  logic              full_s;
  logic              empty_s;
  logic              wr_acc_s;
  logic              rd_acc_s;
  logic              drop_s;
  logic [ADDR_W:0]   level_nxt_s;

  // Accept/drop decisions use occupancy as it stood at the start of the cycle.
  always_comb begin
    full_s      = (level_r == FULL_LVL);
    empty_s     = (level_r == ZERO_LVL);
    wr_acc_s    = 1'b0;
    rd_acc_s    = 1'b0;
    drop_s      = 1'b0;
    level_nxt_s = level_r;
    if (flush) begin
      level_nxt_s = ZERO_LVL;
    end else begin
      wr_acc_s = UART_ctrl_FIFO_w_en & ~full_s;
      rd_acc_s = rd_en & ~empty_s;
      drop_s   = UART_ctrl_FIFO_w_en & full_s;
      case ({wr_acc_s, rd_acc_s})
        2'b10:   level_nxt_s = level_r + LVL_ONE;
        2'b01:   level_nxt_s = level_r - LVL_ONE;
        default: level_nxt_s = level_r;
      endcase
    end
  end

  // Storage array is intentionally left out of reset.
  always_ff @(posedge glb_clk) begin
    if (!glb_rst && wr_acc_s) begin
      mem_r[wr_ptr_r] <= UART_Rx_data_payload;
    end
  end

  // Pointers, occupancy, read output register and overrun flag.
  always_ff @(posedge glb_clk) begin
    if (glb_rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      level_r    <= ZERO_LVL;
      rd_data_r  <= 8'h00;
      rd_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
    end else begin
      level_r    <= level_nxt_s;
      rd_valid_r <= rd_acc_s;
      if (flush) begin
        wr_ptr_r <= '0;
        rd_ptr_r <= '0;
      end else begin
        if (wr_acc_s) begin
          wr_ptr_r <= wr_ptr_r + PTR_ONE;
        end
        if (rd_acc_s) begin
          rd_ptr_r  <= rd_ptr_r + PTR_ONE;
          rd_data_r <= mem_r[rd_ptr_r];
        end
      end
      // A drop in the same cycle as ovr_clr keeps the flag set.
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (ovr_clr) begin
        overrun_r <= 1'b0;
      end
    end
  end

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
  logic irq_r;

  // Threshold of zero disables the level term; overrun always raises irq.
  always_ff @(posedge glb_clk) begin
    if (glb_rst) begin
      irq_r <= 1'b0;
    end else begin
      irq_r <= ((thresh != ZERO_LVL) && (level_r >= thresh)) || overrun_r;
    end
  end

  assign irq = irq_r;
`endif

  assign FIFO_ctrl_full = full_s;
  assign empty          = empty_s;
  assign level          = level_r;
  assign rd_data        = rd_data_r;
  assign rd_valid       = rd_valid_r;
  assign overrun        = overrun_r;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo: directed scenarios plus random traffic against a queue model.
// Define UART_RX_FIFO_THRESH_IRQ_EN for both files to exercise the threshold interrupt.
module tb_uart_rx_fifo;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              glb_clk;
  logic              glb_rst;
  logic [7:0]        pay;
  logic              w_en;
  logic              full;
  logic              rd_en;
  logic [7:0]        rd_data;
  logic              rd_valid;
  logic              empty;
  logic [ADDR_W:0]   level;
  logic              flush;
  logic              overrun;
  logic              ovr_clr;
  logic [ADDR_W:0]   thresh;
  logic              irq;

  int checks;
  int failures;

  byte unsigned mq[$];
  logic [7:0]   m_rd_data;
  logic         m_rd_valid;
  logic         m_ovr;
  logic         m_irq;

  uart_rx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .glb_clk              (glb_clk),
    .glb_rst              (glb_rst),
    .UART_Rx_data_payload (pay),
    .UART_ctrl_FIFO_w_en  (w_en),
    .FIFO_ctrl_full       (full),
    .rd_en                (rd_en),
    .rd_data              (rd_data),
    .rd_valid             (rd_valid),
    .empty                (empty),
    .level                (level),
    .flush                (flush),
    .overrun              (overrun),
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    .thresh               (thresh),
    .irq                  (irq),
`endif
    .ovr_clr              (ovr_clr)
  );

`ifndef UART_RX_FIFO_THRESH_IRQ_EN
  assign irq = 1'b0;
`endif

  initial begin
    glb_clk = 1'b0;
    forever #5 glb_clk = ~glb_clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference: FIFO as a queue, with flags derived from its size before each edge.
  task automatic model_step();
    int   sz;
    logic drop;
    logic irq_n;
    sz    = mq.size();
    drop  = 1'b0;
    irq_n = ((thresh != 0) && (sz >= int'(thresh))) || m_ovr;
    if (glb_rst) begin
      mq.delete();
      m_rd_data  = 8'h00;
      m_rd_valid = 1'b0;
      m_ovr      = 1'b0;
      m_irq      = 1'b0;
    end else begin
      m_irq      = irq_n;
      m_rd_valid = 1'b0;
      if (flush) begin
        mq.delete();
      end else begin
        if (rd_en && sz != 0) begin
          m_rd_data  = mq.pop_front();
          m_rd_valid = 1'b1;
        end
        if (w_en) begin
          if (sz < DEPTH) mq.push_back(pay);
          else            drop = 1'b1;
        end
      end
      if (drop)         m_ovr = 1'b1;
      else if (ovr_clr) m_ovr = 1'b0;
    end
  endtask

  task automatic compare_all();
    check_eq("level",    32'(level),    32'(mq.size()));
    check_eq("empty",    32'(empty),    32'(mq.size() == 0));
    check_eq("full",     32'(full),     32'(mq.size() == DEPTH));
    check_eq("rd_valid", 32'(rd_valid), 32'(m_rd_valid));
    check_eq("rd_data",  32'(rd_data),  32'(m_rd_data));
    check_eq("overrun",  32'(overrun),  32'(m_ovr));
`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    check_eq("irq",      32'(irq),      32'(m_irq));
`endif
  endtask

  task automatic cycle(input logic r, input logic w, input logic [7:0] d,
                       input logic rd, input logic f, input logic c);
    glb_rst = r; w_en = w; pay = d; rd_en = rd; flush = f; ovr_clr = c;
    @(posedge glb_clk);
    #1;
    model_step();
    compare_all();
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [7:0] first_b;
    checks = 0; failures = 0;
    m_rd_data = 8'h00; m_rd_valid = 1'b0; m_ovr = 1'b0; m_irq = 1'b0;
    thresh = '0;
    glb_rst = 1'b1; w_en = 1'b0; pay = 8'h00; rd_en = 1'b0; flush = 1'b0; ovr_clr = 1'b0;

    // Reset state.
    cycle(1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0);
    check_eq("rst_empty", 32'(empty), 32'd1);
    check_eq("rst_level", 32'(level), 32'd0);

    // Two bytes in, two out in order.
    cycle(1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h3C, 1'b0, 1'b0, 1'b0);
    check_eq("two_level", 32'(level), 32'd2);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("rd1_data", 32'(rd_data), 32'h0A5);
    check_eq("rd1_valid", 32'(rd_valid), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("rd2_data", 32'(rd_data), 32'h03C);
    check_eq("rd2_empty", 32'(empty), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("rd_empty_novalid", 32'(rd_valid), 32'd0);
    check_eq("rd_empty_hold", 32'(rd_data), 32'h03C);

    // Fill, overflow, clear.
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 1'b1, 8'(i + 8'h40), 1'b0, 1'b0, 1'b0);
    check_eq("fill_full", 32'(full), 32'd1);
    check_eq("fill_level", 32'(level), 32'd16);
    cycle(1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 1'b0);
    check_eq("ovf_flag", 32'(overrun), 32'd1);
    check_eq("ovf_level", 32'(level), 32'd16);
    cycle(1'b0, 1'b1, 8'hFE, 1'b0, 1'b0, 1'b1);
    check_eq("ovf_set_beats_clr", 32'(overrun), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    check_eq("ovf_clr", 32'(overrun), 32'd0);

    // Full plus simultaneous read and write.
    first_b = mq[0];
    cycle(1'b0, 1'b1, 8'hEE, 1'b1, 1'b0, 1'b0);
    check_eq("fullrw_data", 32'(rd_data), 32'h040);
    check_eq("fullrw_model", 32'(rd_data), 32'(first_b));
    check_eq("fullrw_ovr", 32'(overrun), 32'd1);
    check_eq("fullrw_level", 32'(level), 32'd15);

    // Pointer wrap with concurrent traffic.
    cycle(1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1);
    cycle(1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("emptyrw_level", 32'(level), 32'd1);
    for (int i = 0; i < 40; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b1, 1'b0, 1'b0);

    // Flush with a simultaneous write; then reset during a read.
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    check_eq("flush_level", 32'(level), 32'd0);
    check_eq("flush_empty", 32'(empty), 32'd1);
    check_eq("flush_novalid", 32'(rd_valid), 32'd0);
    cycle(1'b0, 1'b1, 8'h12, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, 1'b1, 8'h34, 1'b1, 1'b0, 1'b0);
    cycle(1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    check_eq("rstrd_valid", 32'(rd_valid), 32'd0);
    check_eq("rstrd_data", 32'(rd_data), 32'd0);
    check_eq("rstrd_level", 32'(level), 32'd0);

`ifdef UART_RX_FIFO_THRESH_IRQ_EN
    thresh = 5'd4;
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
    idle();
    check_eq("irq_below", 32'(irq), 32'd0);
    cycle(1'b0, 1'b1, 8'h03, 1'b0, 1'b0, 1'b0);
    idle();
    check_eq("irq_at", 32'(irq), 32'd1);
    cycle(1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle();
    check_eq("irq_after_rd", 32'(irq), 32'd0);
`endif

    // Random traffic in phases biased towards filling or draining.
    for (int p = 0; p < 12; p++) begin
      int wpct;
      int rpct;
      wpct = (p % 2 == 0) ? 85 : 30;
      rpct = (p % 2 == 0) ? 25 : 80;
      thresh = 5'($urandom_range(0, DEPTH));
      for (int i = 0; i < 200; i++) begin
        cycle(1'($urandom_range(0, 199) == 0),
              1'($urandom_range(0, 99) < wpct),
              8'($urandom),
              1'($urandom_range(0, 99) < rpct),
              1'($urandom_range(0, 99) < 2),
              1'($urandom_range(0, 99) < 5));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
